// File: rtl/alu_flags_pkg.sv
// Shared op encoding and flag bit positions for the ALU flags unit.
package alu_flags_pkg;

    typedef enum logic [2:0] {
        OP_PASS  = 3'b000,
        OP_ADD   = 3'b001,
        OP_ADDNB = 3'b010,
        OP_DEC   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_NOT   = 3'b111
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_flags_core.sv
// Combinational ALU datapath: operands, opcode and carry-in to result and {V,N,Z,C}.
module alu_flags_core
    import alu_flags_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       H,
    input  logic             Cin,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] w_beff;
    logic [WIDTH:0]   w_sum;
    logic             w_arith;
    op_e              w_op;

    assign w_op    = op_e'(H);
    assign w_arith = ~H[2];

    always_comb begin
        w_beff = '0;
        case (H[1:0])
            2'b00:   w_beff = '0;
            2'b01:   w_beff = B;
            2'b10:   w_beff = ~B;
            default: w_beff = '1;
        endcase
    end

    // One extra bit on the adder so the carry out of the MSB is captured directly.
    assign w_sum = {1'b0, A} + {1'b0, w_beff} + {{WIDTH{1'b0}}, Cin};

    always_comb begin
        F = '0;
        case (w_op)
            OP_AND:  F = A & B;
            OP_OR:   F = A | B;
            OP_XOR:  F = A ^ B;
            OP_NOT:  F = ~A;
            default: F = w_sum[WIDTH-1:0];
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = F[WIDTH-1];
        flags[FLAG_Z] = (F == '0);
        if (w_arith) begin
            flags[FLAG_C] = w_sum[WIDTH];
            flags[FLAG_V] = (A[WIDTH-1] == w_beff[WIDTH-1]) && (F[WIDTH-1] != A[WIDTH-1]);
        end
    end

endmodule

// File: rtl/alu_flags_unit.sv
// Registered ALU with condition flags; optional sticky flag accumulator under ALU_FLAGS_STICKY_EN.
module alu_flags_unit
    import alu_flags_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       H,
    input  logic             Cin,
`ifdef ALU_FLAGS_STICKY_EN
    input  logic             sticky_clr,
    output logic [3:0]       sticky_flags,
`endif
    output logic [WIDTH-1:0] F,
    output logic [3:0]       ALUflags
);

    logic [WIDTH-1:0] w_f;
    logic [3:0]       w_flags;
    logic [WIDTH-1:0] r_f;
    logic [3:0]       r_flags;

    alu_flags_core #(.WIDTH(WIDTH)) u_core (
        .A     (A),
        .B     (B),
        .H     (H),
        .Cin   (Cin),
        .F     (w_f),
        .flags (w_flags)
    );

    // Z deliberately reads 0 in reset: flags are meaningless until the first capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f     <= '0;
            r_flags <= '0;
        end else if (en) begin
            r_f     <= w_f;
            r_flags <= w_flags;
        end
    end

    assign F        = r_f;
    assign ALUflags = r_flags;

`ifdef ALU_FLAGS_STICKY_EN
    logic [3:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (sticky_clr) begin
            r_sticky <= en ? w_flags : 4'b0000;
        end else if (en) begin
            r_sticky <= r_sticky | w_flags;
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_alu_flags_unit.sv
// Directed-vector bench for alu_flags_unit; sticky checks compile in with ALU_FLAGS_STICKY_EN.
module tb_alu_flags_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] A, B;
    logic [2:0] H;
    logic       Cin;
    logic [3:0] F;
    logic [3:0] ALUflags;
`ifdef ALU_FLAGS_STICKY_EN
    logic       sticky_clr;
    logic [3:0] sticky_flags;
`endif

    int checks = 0;
    int errors = 0;

    alu_flags_unit #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .A            (A),
        .B            (B),
        .H            (H),
        .Cin          (Cin),
`ifdef ALU_FLAGS_STICKY_EN
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
`endif
        .F            (F),
        .ALUflags     (ALUflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] ef, input logic [3:0] efl);
        checks++;
        assert (F === ef) else begin
            errors++;
            $error("FAIL %s F: observed %b expected %b", tag, F, ef);
        end
        checks++;
        assert (ALUflags === efl) else begin
            errors++;
            $error("FAIL %s ALUflags: observed %b expected %b", tag, ALUflags, efl);
        end
    endtask

    // Drive after a falling edge, capture on the next rising edge, sample 1 time unit later.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] h, input logic cin,
                        input logic [3:0] ef, input logic [3:0] efl);
        @(negedge clk);
        A = a; B = b; H = h; Cin = cin; en = 1'b1;
        @(posedge clk);
        #1;
        chk(tag, ef, efl);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; A = '0; B = '0; H = '0; Cin = 1'b0;
`ifdef ALU_FLAGS_STICKY_EN
        sticky_clr = 1'b0;
`endif
        #12;
        chk("reset", 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        step("pass_c0",  4'b0001, 4'b0010, 3'b000, 1'b0, 4'b0001, 4'b0000);
        step("pass_c1",  4'b0001, 4'b0010, 3'b000, 1'b1, 4'b0010, 4'b0000);
        step("add_c0",   4'b0001, 4'b0010, 3'b001, 1'b0, 4'b0011, 4'b0000);
        step("add_c1",   4'b0001, 4'b0010, 3'b001, 1'b1, 4'b0100, 4'b0000);
        step("addnb_c0", 4'b0001, 4'b0010, 3'b010, 1'b0, 4'b1110, 4'b0100);
        step("addnb_c1", 4'b0001, 4'b0010, 3'b010, 1'b1, 4'b1111, 4'b0100);
        step("dec_c0",   4'b0001, 4'b0010, 3'b011, 1'b0, 4'b0000, 4'b0011);
        step("dec_c1",   4'b0001, 4'b0010, 3'b011, 1'b1, 4'b0001, 4'b0001);
        step("and",      4'b0001, 4'b0010, 3'b100, 1'b1, 4'b0000, 4'b0010);
        step("or",       4'b0001, 4'b0010, 3'b101, 1'b1, 4'b0011, 4'b0000);
        step("xor",      4'b0001, 4'b0010, 3'b110, 1'b1, 4'b0011, 4'b0000);
        step("not",      4'b0001, 4'b0010, 3'b111, 1'b1, 4'b1110, 4'b0100);
        step("zero",     4'b0000, 4'b0000, 3'b001, 1'b0, 4'b0000, 4'b0010);
        step("nonzero",  4'b0000, 4'b0001, 3'b001, 1'b0, 4'b0001, 4'b0000);
        step("carry",    4'b1111, 4'b0010, 3'b001, 1'b0, 4'b0001, 4'b0001);
        step("negative", 4'b0001, 4'b0010, 3'b010, 1'b1, 4'b1111, 4'b0100);
        step("ovf_add",  4'b0111, 4'b0111, 3'b001, 1'b0, 4'b1110, 4'b1100);
        step("ovf_sub",  4'b1001, 4'b0111, 3'b010, 1'b1, 4'b0010, 4'b1001);
        step("max_sub",  4'b1111, 4'b1111, 3'b010, 1'b1, 4'b0000, 4'b0011);

        // Hold: en low while inputs change across two edges.
        @(negedge clk);
        en = 1'b0; A = 4'b0111; B = 4'b0111; H = 3'b001; Cin = 1'b1;
        @(posedge clk); #1;
        chk("hold1", 4'b0000, 4'b0011);
        @(negedge clk);
        A = 4'b0101; H = 3'b111;
        @(posedge clk); #1;
        chk("hold2", 4'b0000, 4'b0011);

        // Asynchronous reset between edges, with a capture pending.
        step("pre_rst",  4'b0001, 4'b0010, 3'b111, 1'b0, 4'b1110, 4'b0100);
        @(negedge clk);
        A = 4'b0111; B = 4'b0111; H = 3'b001; en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 4'b0000, 4'b0000);
        @(posedge clk); #1;
        chk("rst_discard", 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 4'b0111, 4'b0111, 3'b001, 1'b0, 4'b1110, 4'b1100);

`ifdef ALU_FLAGS_STICKY_EN
        @(negedge clk);
        sticky_clr = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        checks++;
        assert (sticky_flags === 4'b0000) else begin
            errors++; $error("FAIL sticky_init: observed %b expected %b", sticky_flags, 4'b0000);
        end
        @(negedge clk);
        sticky_clr = 1'b0;
        step("st_carry", 4'b1111, 4'b0010, 3'b001, 1'b0, 4'b0001, 4'b0001);
        checks++;
        assert (sticky_flags === 4'b0001) else begin
            errors++; $error("FAIL sticky_carry: observed %b expected %b", sticky_flags, 4'b0001);
        end
        step("st_neg", 4'b0001, 4'b0010, 3'b010, 1'b1, 4'b1111, 4'b0100);
        checks++;
        assert (sticky_flags === 4'b0101) else begin
            errors++; $error("FAIL sticky_or: observed %b expected %b", sticky_flags, 4'b0101);
        end
        @(negedge clk);
        sticky_clr = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        checks++;
        assert (sticky_flags === 4'b0000) else begin
            errors++; $error("FAIL sticky_clr: observed %b expected %b", sticky_flags, 4'b0000);
        end
        @(negedge clk);
        sticky_clr = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flags_unit.md
# alu_flags_unit

Registered 4-bit ALU with carry-in that produces a result and a four-bit condition-flag vector {V,N,Z,C}. It sits in the datapath execute stage. The core is combinational operand/opcode decode. Result and flags are captured in output registers on the clock.

## Interface
- `WIDTH`, default 4, datapath width in bits; all values below assume 4.
- `clk` input, 1 bit, rising-edge clock.
- `rst_n` input, 1 bit, asynchronous active-low reset.
- `en` input, 1 bit, capture enable for the output registers.
- `A` input, WIDTH bits, operand A.
- `B` input, WIDTH bits, operand B.
- `H` input, 3 bits, operation select.
- `Cin` input, 1 bit, carry-in; used by arithmetic ops only.
- `F` output, WIDTH bits, registered result.
- `ALUflags` output, 4 bits, registered flags: bit3=V, bit2=N, bit1=Z, bit0=C.
- `sticky_clr` input, 1 bit; present only with `ALU_FLAGS_STICKY_EN`.
- `sticky_flags` output, 4 bits; present only with `ALU_FLAGS_STICKY_EN`.

## Operation
- Arithmetic ops compute F = A + Beff + Cin, modulo 2^WIDTH:
  - H=000: Beff=0, giving A + Cin.
  - H=001: Beff=B, giving A + B + Cin.
  - H=010: Beff=~B, giving A + ~B + Cin; subtract when Cin=1.
  - H=011: Beff=all-ones, giving A − 1 + Cin.
- Logic ops:
  - H=100: F = A & B.
  - H=101: F = A | B.
  - H=110: F = A ^ B.
  - H=111: F = ~A.
  - Cin is ignored for all logic ops.
- Flags for all ops:
  - N = F[WIDTH-1].
  - Z = 1 iff F is all-zero.
- Flags for arithmetic ops:
  - C = carry out of bit WIDTH-1 of the full (WIDTH+1)-bit sum A + Beff + Cin.
  - V = (A[MSB] == Beff[MSB]) && (F[MSB] != A[MSB]).
- Flags for logic ops: C=0 and V=0.
- No X propagation; every H value is defined.

## Timing
- Latency is 1 cycle: inputs sampled at a rising edge with en=1 appear on F/ALUflags after that edge.
- en=0: F and ALUflags hold their values.
- Asynchronous reset (rst_n=0): F=0 and ALUflags=4'b0000.
  - Z reads 0 in reset even though F=0; flags are valid only after the first enabled capture.
- Reset asserted mid-operation clears the registers immediately and discards any pending capture.
- No handshake and no state machine.

## Configuration
- `ALU_FLAGS_STICKY_EN` defined:
  - Adds `sticky_clr` and `sticky_flags`.
  - On each enabled capture, sticky_flags |= new ALUflags.
  - sticky_clr=1 at an edge: sticky_flags loads the new flags if en=1, otherwise 0. Clear beats accumulate.
  - Reset value is 0.
- `ALU_FLAGS_STICKY_EN` undefined: these ports and registers do not exist.

## Structure
- Package `alu_flags_pkg` holds:
  - The op enum: OP_PASS=000, OP_ADD=001, OP_ADDNB=010, OP_DEC=011, OP_AND=100, OP_OR=101, OP_XOR=110, OP_NOT=111.
  - Flag index constants: FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
- Sub-module `alu_flags_core` is purely combinational: A/B/H/Cin to next F and flags.
- The top level adds the registers and the optional sticky logic.

## Test plan
- Ops sweep, A=0001, B=0010, one enabled cycle each:
  - H=000: Cin 0/1 gives F=0001/0010.
  - H=001: Cin 0/1 gives F=0011/0100.
  - H=010: Cin 0/1 gives F=1110/1111.
  - H=011: Cin 0/1 gives F=0000/0001.
  - H=100..111 give F=0000, 0011, 0011, 1110.
- Zero: A=0, B=0, H=001, Cin=0 gives ALUflags=0010; with B=0001 it gives 0000.
- Carry: A=1111, B=0010, H=001, Cin=0 gives F=0001, ALUflags=0001.
- Negative: A=0001, B=0010, H=010, Cin=1 gives F=1111, ALUflags=0100.
- Overflow:
  - Add: A=0111, B=0111, H=001, Cin=0 gives ALUflags=1100.
  - Subtract: A=1001, B=0111, H=010, Cin=1 gives F=0010, ALUflags=1001.
- Control and reset:
  - en=0 holds F/ALUflags across input changes.
  - rst_n low mid-run clears outputs asynchronously to 0.
  - With the macro, sticky_flags ORs the carry then negative cases to 0101, and sticky_clr returns it to 0.
